// File: rtl/display_clocks_pkg.sv
// Shared types and the per-mode MMCME2 DRP register table for display_clocks_drp.
package display_clocks_pkg;

  localparam int NREGS = 23;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } drp_entry_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_MODE = 2'd1,
    ERR_DRDY = 2'd2,
    ERR_LOCK = 2'd3
  } err_t;

  typedef enum logic [3:0] {
    ST_START, ST_RST_ON, ST_RD, ST_RD_WAIT, ST_WR, ST_WR_WAIT,
    ST_RB, ST_RB_WAIT, ST_RST_OFF, ST_LOCK_WAIT, ST_IDLE
  } state_t;

  // Integer divider settings per mode, all from a 100 MHz reference.
  typedef struct packed {
    logic [6:0]  div;
    logic [6:0]  mult;
    logic [6:0]  out0;
    logic [6:0]  out1;
    logic [9:0]  lock_cnt;
    logic [4:0]  lock_dly;
    logic [15:0] filt1;
    logic [15:0] filt2;
  } mode_cfg_t;

  // 0: 25.2 MHz (M53/D7/O30), 1: 40 MHz (M10/D1/O25),
  // 2: 65 MHz (M13/D2/O10), 3: 74.25 MHz (M52/D7/O10); CLKOUT1 is the 5x clock.
  function automatic mode_cfg_t mode_cfg(input logic [2:0] mode);
    mode_cfg_t c;
    case (mode)
      3'd0:    c = '{7'd7, 7'd53, 7'd30, 7'd6, 10'd1000, 5'd31, 16'h0900, 16'h1190};
      3'd1:    c = '{7'd1, 7'd10, 7'd25, 7'd5, 10'd1000, 5'd25, 16'h0800, 16'h9190};
      3'd3:    c = '{7'd7, 7'd52, 7'd10, 7'd2, 10'd1000, 5'd31, 16'h1900, 16'h0190};
      default: c = '{7'd2, 7'd13, 7'd10, 7'd2, 10'd1000, 5'd28, 16'h0900, 16'h1190};
    endcase
    return c;
  endfunction

  // ClkReg1: high/low time for a 50 % duty integer divide.
  function automatic logic [15:0] clk_reg1(input logic [6:0] d);
    logic [6:0] ht;
    logic [6:0] lt;
    ht = d >> 1;
    lt = d - ht;
    if (d == 7'd1) begin
      ht = 7'd1;
      lt = 7'd1;
    end
    return {4'b0000, ht[5:0], lt[5:0]};
  endfunction

  // ClkReg2: edge for odd divides, no_count for divide-by-one.
  function automatic logic [15:0] clk_reg2(input logic [6:0] d);
    return {8'h00, (d[0] && d != 7'd1), (d == 7'd1), 6'b000000};
  endfunction

  function automatic logic [15:0] div_reg(input logic [6:0] d);
    logic [15:0] r1;
    logic [15:0] r2;
    r1 = clk_reg1(d);
    r2 = clk_reg2(d);
    return {2'b00, r2[7], r2[6], r1[11:0]};
  endfunction

  // Mode table: one {addr, mask, data} row per configuration register.
  function automatic drp_entry_t mode_table(input logic [2:0] mode, input logic [4:0] idx);
    mode_cfg_t  c;
    drp_entry_t e;
    c = mode_cfg(mode);
    case (idx)
      5'd1:    e = '{7'h08, 16'h1000, clk_reg1(c.out0)};
      5'd2:    e = '{7'h09, 16'hFC00, clk_reg2(c.out0)};
      5'd3:    e = '{7'h0A, 16'h1000, clk_reg1(c.out1)};
      5'd4:    e = '{7'h0B, 16'hFC00, clk_reg2(c.out1)};
      5'd5:    e = '{7'h0C, 16'h1000, clk_reg1(c.out0)};
      5'd6:    e = '{7'h0D, 16'hFC00, clk_reg2(c.out0)};
      5'd7:    e = '{7'h0E, 16'h1000, clk_reg1(c.out0)};
      5'd8:    e = '{7'h0F, 16'hFC00, clk_reg2(c.out0)};
      5'd9:    e = '{7'h10, 16'h1000, clk_reg1(c.out0)};
      5'd10:   e = '{7'h11, 16'hFC00, clk_reg2(c.out0)};
      5'd11:   e = '{7'h06, 16'h1000, clk_reg1(c.out0)};
      5'd12:   e = '{7'h07, 16'hFC00, clk_reg2(c.out0)};
      5'd13:   e = '{7'h12, 16'h1000, clk_reg1(c.out0)};
      5'd14:   e = '{7'h13, 16'hFC00, clk_reg2(c.out0)};
      5'd15:   e = '{7'h16, 16'hC000, div_reg(c.div)};
      5'd16:   e = '{7'h14, 16'h1000, clk_reg1(c.mult)};
      5'd17:   e = '{7'h15, 16'hFC00, clk_reg2(c.mult)};
      5'd18:   e = '{7'h18, 16'hFC00, {6'b000000, c.lock_cnt}};
      5'd19:   e = '{7'h19, 16'h8000, {1'b0, c.lock_dly, 10'h001}};
      5'd20:   e = '{7'h1A, 16'h8000, {1'b0, c.lock_dly, 10'h3E9}};
      5'd21:   e = '{7'h4E, 16'h6600, c.filt1};
      5'd22:   e = '{7'h4F, 16'h6666, c.filt2};
      default: e = '{7'h28, 16'h0000, 16'hFFFF};
    endcase
    // Data never touches the bits the mask preserves.
    e.data = e.data & ~e.mask;
    return e;
  endfunction

endpackage

// File: rtl/display_clocks_drp_xfer.sv
// Single DRP read or write: strobe, address/data hold, DRDY wait with timeout.
module display_clocks_drp_xfer #(
  parameter int DRDY_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [6:0]  addr_i,
  input  logic [15:0] di_i,
  input  logic        drp_rdy_i,
  output logic        drp_en_o,
  output logic        drp_we_o,
  output logic [6:0]  drp_addr_o,
  output logic [15:0] drp_di_o,
  output logic        done_o,
  output logic        timeout_o
);

  localparam int CW = $clog2(DRDY_TIMEOUT + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    addr_q, addr_d;
  logic [15:0]   di_q, di_d;

  // Strobe passes straight through; address/data are held from the strobe until rdy.
  always_comb begin
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    di_d       = di_q;
    drp_en_o   = start_i;
    drp_we_o   = start_i & we_i;
    drp_addr_o = start_i ? addr_i : addr_q;
    drp_di_o   = start_i ? di_i : di_q;
    // rdy only counts after the strobe cycle; cnt_q is cycles since the strobe.
    done_o     = busy_q && drp_rdy_i;
    timeout_o  = busy_q && !drp_rdy_i && (cnt_q == CW'(DRDY_TIMEOUT - 1));
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CW'(1);
      addr_d = addr_i;
      di_d   = di_i;
    end else if (busy_q) begin
      if (done_o || timeout_o) busy_d = 1'b0;
      else                     cnt_d  = cnt_q + CW'(1);
    end
  end

  // Transfer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      addr_q <= '0;
      di_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      di_q   <= di_d;
    end
  end

endmodule

// File: rtl/display_clocks_drp.sv
// Display-mode clock controller: reprograms an MMCME2_ADV over DRP
// (reset, read-modify-write of every register, lock wait, timeouts).
// Optional: define DISPLAY_CLOCKS_DRP_READBACK_EN to verify each write by readback.
module display_clocks_drp
  import display_clocks_pkg::*;
#(
  parameter int N_MODES      = 4,
  parameter int DEFAULT_MODE = 2,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65536,
  localparam int MODE_W      = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  input  logic [MODE_W-1:0] i_req_mode,
  output logic              o_req_ready,
  output logic [6:0]        o_drp_addr,
  output logic [15:0]       o_drp_di,
  input  logic [15:0]       i_drp_do,
  output logic              o_drp_en,
  output logic              o_drp_we,
  input  logic              i_drp_rdy,
  output logic              o_mmcm_rst,
  input  logic              i_mmcm_locked,
  output logic              o_locked,
  output logic              o_busy,
  output logic [MODE_W-1:0] o_mode,
  output logic [1:0]        o_err
);

  localparam int LCW = $clog2(LOCK_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  err_t              err_q, err_d;
  logic              busy_q, busy_d;
  logic              mmcm_rst_q, mmcm_rst_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic              lock_s1_q, lock_s2_q;

  drp_entry_t entry;
  logic       xfer_start, xfer_we, xfer_done, xfer_tmo;
  logic       step_next, fail_drp;

  assign entry = mode_table(3'(mode_q), idx_q);

  display_clocks_drp_xfer #(.DRDY_TIMEOUT(DRDY_TIMEOUT)) u_xfer (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .start_i    (xfer_start),
    .we_i       (xfer_we),
    .addr_i     (entry.addr),
    .di_i       ((rdata_q & entry.mask) | entry.data),
    .drp_rdy_i  (i_drp_rdy),
    .drp_en_o   (o_drp_en),
    .drp_we_o   (o_drp_we),
    .drp_addr_o (o_drp_addr),
    .drp_di_o   (o_drp_di),
    .done_o     (xfer_done),
    .timeout_o  (xfer_tmo)
  );

  // Sequencer next-state logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    err_d      = err_q;
    busy_d     = busy_q;
    mmcm_rst_d = mmcm_rst_q;
    rdata_d    = rdata_q;
    lock_cnt_d = lock_cnt_q;
    xfer_start = 1'b0;
    xfer_we    = 1'b0;
    step_next  = 1'b0;
    fail_drp   = 1'b0;
    case (state_q)
      ST_START: begin
        mode_d  = MODE_W'(DEFAULT_MODE);
        busy_d  = 1'b1;
        state_d = ST_RST_ON;
      end
      ST_RST_ON: begin
        mmcm_rst_d = 1'b1;
        idx_d      = '0;
        state_d    = ST_RD;
      end
      ST_RD: begin
        xfer_start = 1'b1;
        state_d    = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (xfer_done) begin
          rdata_d = i_drp_do;
          state_d = ST_WR;
        end else if (xfer_tmo) begin
          fail_drp = 1'b1;
        end
      end
      ST_WR: begin
        xfer_start = 1'b1;
        xfer_we    = 1'b1;
        state_d    = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (xfer_done) begin
`ifdef DISPLAY_CLOCKS_DRP_READBACK_EN
          state_d = ST_RB;
`else
          step_next = 1'b1;
`endif
        end else if (xfer_tmo) begin
          fail_drp = 1'b1;
        end
      end
`ifdef DISPLAY_CLOCKS_DRP_READBACK_EN
      ST_RB: begin
        xfer_start = 1'b1;
        state_d    = ST_RB_WAIT;
      end
      ST_RB_WAIT: begin
        if (xfer_done) begin
          // Only the bits we wrote are compared; preserved bits may read anything.
          if (((i_drp_do ^ entry.data) & ~entry.mask) != 16'h0000) fail_drp  = 1'b1;
          else                                                      step_next = 1'b1;
        end else if (xfer_tmo) begin
          fail_drp = 1'b1;
        end
      end
`endif
      ST_RST_OFF: begin
        mmcm_rst_d = 1'b0;
        lock_cnt_d = '0;
        state_d    = ST_LOCK_WAIT;
      end
      ST_LOCK_WAIT: begin
        if (lock_s2_q) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (lock_cnt_q == LCW'(LOCK_TIMEOUT - 1)) begin
          err_d   = ERR_LOCK;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
      ST_IDLE: begin
        if (i_req_valid) begin
          if (32'(i_req_mode) < N_MODES) begin
            mode_d  = i_req_mode;
            err_d   = ERR_NONE;
            busy_d  = 1'b1;
            state_d = ST_RST_ON;
          end else begin
            err_d = ERR_MODE;
          end
        end
      end
      default: state_d = ST_START;
    endcase
    // MMCM stays in reset after a DRP failure so a half-written config never runs.
    if (fail_drp) begin
      err_d   = ERR_DRDY;
      busy_d  = 1'b0;
      state_d = ST_IDLE;
    end
    if (step_next) begin
      if (idx_q == 5'(NREGS - 1)) begin
        state_d = ST_RST_OFF;
      end else begin
        idx_d   = idx_q + 5'd1;
        state_d = ST_RD;
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_START;
      idx_q      <= '0;
      mode_q     <= MODE_W'(DEFAULT_MODE);
      err_q      <= ERR_NONE;
      busy_q     <= 1'b1;
      mmcm_rst_q <= 1'b1;
      rdata_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      mmcm_rst_q <= mmcm_rst_d;
      rdata_q    <= rdata_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Two-flop synchroniser for the asynchronous MMCM LOCKED output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
    end else begin
      lock_s1_q <= i_mmcm_locked;
      lock_s2_q <= lock_s1_q;
    end
  end

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_locked    = lock_s2_q && (state_q == ST_IDLE);
  assign o_busy      = busy_q;
  assign o_mmcm_rst  = mmcm_rst_q;
  assign o_mode      = mode_q;
  assign o_err       = err_q;

endmodule
